regfile_writeback: RTL and testbench

- Register file plus writeback stage directly downstream of the 16-bit signed ALU, which it also feeds.
- Holds sixteen 16-bit registers and drives the ALU `a`/`b` operands from two read ports.
- Captures the ALU result (`r`, `R15`, `ovf`) into a one-entry writeback register, then commits it to the array one cycle later.
- Bypasses the pending value to the read ports and keeps a sticky overflow flag.

---
 rtl/regfile_writeback_if.sv | 30 +++
 rtl/regfile_writeback.sv | 86 ++++++++
 tb/tb_regfile_writeback.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_writeback_if.sv
// Bus between the ALU/issue side and the register file + writeback stage.
// master = ALU side (drives operands addresses and results), slave = register file.
interface regfile_writeback_if #(
    parameter int W = 16
);
    logic [3:0]   ra_addr;
    logic [3:0]   rb_addr;
    logic [W-1:0] a_data;
    logic [W-1:0] b_data;
    logic         wb_valid;
    logic [3:0]   wb_rd;
    logic [2:0]   wb_sel;
    logic [W-1:0] wb_r;
    logic [W-1:0] wb_r15;
    logic         wb_ovf;
    logic         ovf_clr;
    logic         ovf_flag;
    logic         commit_valid;
    logic [3:0]   commit_rd;

    modport master (
        output ra_addr, rb_addr, wb_valid, wb_rd, wb_sel, wb_r, wb_r15, wb_ovf, ovf_clr,
        input  a_data, b_data, ovf_flag, commit_valid, commit_rd
    );

    modport slave (
        input  ra_addr, rb_addr, wb_valid, wb_rd, wb_sel, wb_r, wb_r15, wb_ovf, ovf_clr,
        output a_data, b_data, ovf_flag, commit_valid, commit_rd
    );
endinterface

// File: rtl/regfile_writeback.sv
// Sixteen-entry register file with a one-deep writeback register in front of it.
// The pending entry is bypassed onto both read ports; overflow is accumulated in a sticky flag.
module regfile_writeback #(
    parameter int NREG = 16,
    parameter int W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    regfile_writeback_if.slave  bus
);
    logic [W-1:0] regs [NREG];

    logic         p_v;
    logic [3:0]   p_rd;
    logic [2:0]   p_sel;
    logic [W-1:0] p_r;
    logic [W-1:0] p_r15;
    logic         p_ovf;

    logic         ovf_flag_q;
    logic         commit_valid_q;
    logic [3:0]   commit_rd_q;

    // sel 010/011 also produce R15 (high product half / remainder)
    logic         p_dual;
    assign p_dual = p_v && (p_sel[2:1] == 2'b01);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            p_v            <= 1'b0;
            p_rd           <= '0;
            p_sel          <= '0;
            p_r            <= '0;
            p_r15          <= '0;
            p_ovf          <= 1'b0;
            ovf_flag_q     <= 1'b0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
        end else begin
            p_v <= bus.wb_valid && (bus.wb_sel <= 3'b101);
            if (bus.wb_valid) begin
                p_rd  <= bus.wb_rd;
                p_sel <= bus.wb_sel;
                p_r   <= bus.wb_r;
                p_r15 <= bus.wb_r15;
                p_ovf <= bus.wb_ovf;
            end

            // Primary result wins when rd is 15 on a dual-write op.
            if (p_dual && (p_rd != 4'd15)) begin
                regs[15] <= p_r15;
            end
            if (p_v) begin
                regs[p_rd]  <= p_r;
                commit_rd_q <= p_rd;
            end
            commit_valid_q <= p_v;

            // A same-edge set beats the clear.
            ovf_flag_q <= (ovf_flag_q && !bus.ovf_clr) || (p_v && p_ovf);
        end
    end

    always_comb begin
        bus.a_data = regs[bus.ra_addr];
        if (p_v && (bus.ra_addr == p_rd)) begin
            bus.a_data = p_r;
        end else if (p_dual && (bus.ra_addr == 4'd15) && (p_rd != 4'd15)) begin
            bus.a_data = p_r15;
        end

        bus.b_data = regs[bus.rb_addr];
        if (p_v && (bus.rb_addr == p_rd)) begin
            bus.b_data = p_r;
        end else if (p_dual && (bus.rb_addr == 4'd15) && (p_rd != 4'd15)) begin
            bus.b_data = p_r15;
        end
    end

    assign bus.ovf_flag     = ovf_flag_q;
    assign bus.commit_valid = commit_valid_q;
    assign bus.commit_rd    = commit_rd_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: commits are scoreboarded by a monitor,
// read-port and flag values are checked against hand-computed constants.
module tb_regfile_writeback;
    logic clk = 1'b0;
    logic rst;

    regfile_writeback_if #(.W(16)) bus ();

    regfile_writeback #(.NREG(16), .W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q [$];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue(input logic [3:0] rd, input logic [2:0] sel,
                         input logic [15:0] r, input logic [15:0] r15, input logic ovf);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = rd;
        bus.wb_sel   = sel;
        bus.wb_r     = r;
        bus.wb_r15   = r15;
        bus.wb_ovf   = ovf;
        if (sel <= 3'b101) exp_q.push_back(rd);
    endtask

    task automatic idle();
        bus.wb_valid = 1'b0;
        bus.wb_ovf   = 1'b0;
    endtask

    // Monitor: every commit pulse must match the oldest outstanding writeback.
    always @(negedge clk) begin
        if (!rst && bus.commit_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL commit_unexpected: got rd %0d expected no commit", bus.commit_rd);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (bus.commit_rd !== e) begin
                    n_bad++;
                    $display("FAIL commit_rd: got %0d expected %0d", bus.commit_rd, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.ra_addr = '0; bus.rb_addr = '0; bus.ovf_clr = 1'b0;
        bus.wb_valid = 1'b0; bus.wb_rd = '0; bus.wb_sel = '0;
        bus.wb_r = '0; bus.wb_r15 = '0; bus.wb_ovf = 1'b0;
        tick(); tick();
        rst = 1'b0;

        // Reset mid-run discards a pending entry and ignores a result presented during reset
        bus.wb_valid = 1'b1; bus.wb_rd = 4'd3; bus.wb_sel = 3'b000;
        bus.wb_r = 16'h1234; bus.wb_r15 = '0; bus.wb_ovf = 1'b1;
        tick();
        rst = 1'b1;
        bus.wb_rd = 4'd5; bus.wb_r = 16'h5555;
        tick();
        rst = 1'b0; idle();
        bus.ra_addr = 4'd3; bus.rb_addr = 4'd5;
        check("rst_ovf_flag", {15'd0, bus.ovf_flag}, 16'h0000);
        check("rst_commit_valid", {15'd0, bus.commit_valid}, 16'h0000);
        check("rst_commit_rd", {12'd0, bus.commit_rd}, 16'h0000);
        check("rst_a_data", bus.a_data, 16'h0000);
        check("rst_b_data", bus.b_data, 16'h0000);
        tick(); tick();
        check("rst_reg3_discarded", bus.a_data, 16'h0000);
        check("rst_reg5_ignored", bus.b_data, 16'h0000);
        check("rst_no_ovf", {15'd0, bus.ovf_flag}, 16'h0000);

        // Add: bypass in N+1, array after E(N+1), commit pulse in N+2
        bus.ra_addr = 4'd2;
        issue(4'd2, 3'b000, 16'h0005, 16'h0000, 1'b0);
        tick(); idle();
        check("add_bypass", bus.a_data, 16'h0005);
        check("add_no_commit_yet", {15'd0, bus.commit_valid}, 16'h0000);
        tick();
        check("add_array", bus.a_data, 16'h0005);
        check("add_commit_valid", {15'd0, bus.commit_valid}, 16'h0001);
        tick();
        check("add_commit_pulse_end", {15'd0, bus.commit_valid}, 16'h0000);

        // Multiply dual write
        bus.ra_addr = 4'd4; bus.rb_addr = 4'd15;
        issue(4'd4, 3'b010, 16'h0000, 16'h0001, 1'b0);
        tick(); idle();
        check("mul_bypass_r", bus.a_data, 16'h0000);
        check("mul_bypass_r15", bus.b_data, 16'h0001);
        tick();
        check("mul_reg4", bus.a_data, 16'h0000);
        check("mul_reg15", bus.b_data, 16'h0001);

        // rd=15 on a dual-write op: primary result wins
        issue(4'd15, 3'b011, 16'h0007, 16'h0002, 1'b0);
        tick(); idle();
        check("rd15_bypass", bus.b_data, 16'h0007);
        tick();
        check("rd15_reg15", bus.b_data, 16'h0007);

        // Sticky overflow
        issue(4'd6, 3'b000, 16'h0011, 16'h0000, 1'b1);
        tick();
        check("ovf_not_before_commit", {15'd0, bus.ovf_flag}, 16'h0000);
        issue(4'd7, 3'b001, 16'h0012, 16'h0000, 1'b0);
        tick();
        check("ovf_set", {15'd0, bus.ovf_flag}, 16'h0001);
        issue(4'd8, 3'b100, 16'h0013, 16'h0000, 1'b0);
        tick(); idle();
        check("ovf_sticky1", {15'd0, bus.ovf_flag}, 16'h0001);
        tick();
        check("ovf_sticky2", {15'd0, bus.ovf_flag}, 16'h0001);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr_alone", {15'd0, bus.ovf_flag}, 16'h0000);
        issue(4'd9, 3'b101, 16'h0014, 16'h0000, 1'b1);
        tick(); idle();
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_set_beats_clr", {15'd0, bus.ovf_flag}, 16'h0001);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("ovf_clr_again", {15'd0, bus.ovf_flag}, 16'h0000);

        // Back-to-back writes to the same register
        bus.ra_addr = 4'd1; bus.rb_addr = 4'd1;
        issue(4'd1, 3'b000, 16'h0010, 16'h0000, 1'b0);
        tick();
        check("b2b_first", bus.a_data, 16'h0010);
        issue(4'd1, 3'b000, 16'h0020, 16'h0000, 1'b0);
        tick(); idle();
        check("b2b_second_bypass", bus.b_data, 16'h0020);
        tick();
        check("b2b_final_reg1", bus.a_data, 16'h0020);

        // No-op sel=110: no write, no flag, no commit pulse
        bus.rb_addr = 4'd15;
        issue(4'd1, 3'b110, 16'h0099, 16'h0099, 1'b1);
        tick(); idle();
        check("noop_no_bypass", bus.a_data, 16'h0020);
        tick();
        check("noop_reg1", bus.a_data, 16'h0020);
        check("noop_reg15", bus.b_data, 16'h0007);
        check("noop_no_commit", {15'd0, bus.commit_valid}, 16'h0000);
        tick();
        check("noop_no_ovf", {15'd0, bus.ovf_flag}, 16'h0000);

        // Earlier registers still hold their committed values
        bus.ra_addr = 4'd2; bus.rb_addr = 4'd9;
        tick();
        check("hold_reg2", bus.a_data, 16'h0005);
        check("hold_reg9", bus.b_data, 16'h0014);
        tick(); tick();
        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
